// File: rtl/axil_slv_mem_pkg.sv
// Shared types and helpers for the AXI4-Lite memory slave.
// Response codes, FSM state encodings and the address range check.
package axil_slv_mem_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_LAT,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_LAT,
        R_RESP
    } rd_state_e;

    // Widened to 64 bits so base+bytes cannot wrap for any ADDR_W <= 64.
    function automatic logic in_range(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] bytes
    );
        return (addr >= base) && ((addr - base) < bytes);
    endfunction

endpackage

// File: rtl/axil_slv_mem_ram.sv
// Word-wide memory with a byte-enable write port and a registered read sample.
// No reset: contents survive aresetn.
module axil_slv_mem_ram
    import axil_slv_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                re,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read and write share an edge, so a same-word read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axil_slv_mem_resp.sv
// AXI4-Lite slave over an internal memory with programmable B/R latency.
// Define AXIL_SLV_MEM_ERR_INJ_EN to add err_inj_wr/err_inj_rd SLVERR injection.
module axil_slv_mem_resp
    import axil_slv_mem_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                WR_LAT    = 0,
    parameter int                RD_LAT    = 1
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready
`ifdef AXIL_SLV_MEM_ERR_INJ_EN
    ,
    input  logic                err_inj_wr,
    input  logic                err_inj_rd
`endif
);

    localparam int          STRB_W    = DATA_W / 8;
    localparam int          OFF_W     = $clog2(STRB_W);
    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'(STRB_W);

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> OFF_W);
    endfunction

    logic wr_inj;
    logic rd_inj;
`ifdef AXIL_SLV_MEM_ERR_INJ_EN
    assign wr_inj = err_inj_wr;
    assign rd_inj = err_inj_rd;
`else
    assign wr_inj = 1'b0;
    assign rd_inj = 1'b0;
`endif

    wr_state_e           w_state;
    logic [3:0]          w_cnt;
    logic                aw_got;
    logic                w_got;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    resp_e               bresp_q;

    logic                aw_hs;
    logic                w_hs;
    logic                aw_have;
    logic                w_have;
    logic                commit;
    logic [ADDR_W-1:0]   c_addr;
    logic [DATA_W-1:0]   c_data;
    logic [STRB_W-1:0]   c_strb;
    logic                c_ok;

    // Commit uses whichever half arrives this edge, else the captured copy.
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign aw_have = aw_got | aw_hs;
    assign w_have  = w_got | w_hs;
    assign commit  = (w_state == W_IDLE) & aw_have & w_have;
    assign c_addr  = aw_got ? aw_addr_q : awaddr;
    assign c_data  = w_got ? w_data_q : wdata;
    assign c_strb  = w_got ? w_strb_q : wstrb;
    assign c_ok    = in_range(64'(c_addr), 64'(BASE_ADDR), MEM_BYTES);
    assign bresp   = bresp_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state   <= W_IDLE;
            w_cnt     <= 4'd0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (aw_hs) aw_addr_q <= awaddr;
                    if (w_hs) begin
                        w_data_q <= wdata;
                        w_strb_q <= wstrb;
                    end
                    if (commit) begin
                        aw_got  <= 1'b0;
                        w_got   <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        bresp_q <= (!c_ok || wr_inj) ? SLVERR : OKAY;
                        if (WR_LAT == 0) begin
                            w_state <= W_RESP;
                            bvalid  <= 1'b1;
                        end else begin
                            w_state <= W_LAT;
                            w_cnt   <= 4'(WR_LAT - 1);
                        end
                    end else begin
                        aw_got  <= aw_have;
                        w_got   <= w_have;
                        awready <= !aw_have;
                        wready  <= !w_have;
                    end
                end
                W_LAT: begin
                    if (w_cnt == 4'd0) begin
                        w_state <= W_RESP;
                        bvalid  <= 1'b1;
                    end else begin
                        w_cnt <= w_cnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state <= W_IDLE;
                        bvalid  <= 1'b0;
                        bresp_q <= OKAY;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    rd_state_e           r_state;
    logic [3:0]          r_cnt;
    logic                rd_oor;
    resp_e               rresp_q;
    logic                ar_hs;
    logic                ar_ok;
    logic [DATA_W-1:0]   ram_q;

    assign ar_hs = arvalid & arready;
    assign ar_ok = in_range(64'(araddr), 64'(BASE_ADDR), MEM_BYTES);
    assign rresp = rresp_q;
    // The RAM sample holds until the next AR, so it is the delayed read data.
    assign rdata = (rvalid && !rd_oor) ? ram_q : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            r_cnt   <= 4'd0;
            rd_oor  <= 1'b0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rresp_q <= OKAY;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        arready <= 1'b0;
                        rd_oor  <= !ar_ok;
                        rresp_q <= (!ar_ok || rd_inj) ? SLVERR : OKAY;
                        if (RD_LAT == 1) begin
                            r_state <= R_RESP;
                            rvalid  <= 1'b1;
                        end else begin
                            r_state <= R_LAT;
                            r_cnt   <= 4'(RD_LAT - 2);
                        end
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_LAT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= R_RESP;
                        rvalid  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_state <= R_IDLE;
                        rvalid  <= 1'b0;
                        rresp_q <= OKAY;
                        arready <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    axil_slv_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk    (aclk),
        .we     (commit & c_ok),
        .waddr  (word_idx(c_addr)),
        .wdata  (c_data),
        .wstrb  (c_strb),
        .re     (ar_hs),
        .raddr  (word_idx(araddr)),
        .rdata  (ram_q)
    );

endmodule

// File: tb/tb_axil_slv_mem_resp.sv
// Bench for axil_slv_mem_resp: vector table, corner sequences, random vs model.
// Injection checks are active when AXIL_SLV_MEM_ERR_INJ_EN is defined.
module tb_axil_slv_mem_resp;

    localparam int          WR_LAT    = 2;
    localparam int          RD_LAT    = 3;
    localparam int          DEPTH     = 256;
    localparam logic [31:0] BASE      = 32'h0;
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);
`ifdef AXIL_SLV_MEM_ERR_INJ_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        err_inj_wr = 1'b0;
    logic        err_inj_rd = 1'b0;

    axil_slv_mem_resp #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .WR_LAT    (WR_LAT),
        .RD_LAT    (RD_LAT)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
`ifdef AXIL_SLV_MEM_ERR_INJ_EN
        ,
        .err_inj_wr (err_inj_wr),
        .err_inj_rd (err_inj_rd)
`endif
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [DEPTH];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic bit ref_in_range(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + MEM_BYTES);
    endfunction

    function automatic int ref_word(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        int w;
        if (!ref_in_range(a)) return;
        w = ref_word(a);
        for (int b = 0; b < 4; b++)
            if (s[b]) model[w][b*8 +: 8] = d[b*8 +: 8];
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int lead, input bit inj,
                            input int bdelay, output logic [1:0] resp);
        int  aw_start;
        int  w_start;
        int  commit_cyc;
        int  n;
        bit  aw_done;
        bit  w_done;
        bit  aw_hs;
        bit  w_hs;
        aw_done    = 0;
        w_done     = 0;
        commit_cyc = -1;
        resp       = 2'b11;
        aw_start   = lead > 0 ? lead : 0;
        w_start    = lead < 0 ? -lead : 0;
        awaddr     = a;
        wdata      = d;
        wstrb      = s;
        err_inj_wr = inj;
        for (int k = 0; k < 40 && !(aw_done && w_done); k++) begin
            awvalid = !aw_done && k >= aw_start;
            wvalid  = !w_done && k >= w_start;
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            if ((aw_hs || aw_done) && (w_hs || w_done)) commit_cyc = cyc;
            tick();
            aw_done = aw_done | aw_hs;
            w_done  = w_done | w_hs;
        end
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        err_inj_wr = 1'b0;
        if (!(aw_done && w_done)) begin
            check("wr_accept_timeout", 0, 1);
            return;
        end
        n = 0;
        while (!bvalid && n < 40) begin
            tick();
            n++;
        end
        check("wr_latency", 64'(cyc - commit_cyc), 64'(WR_LAT + 1));
        check("wr_readies_low", {awready, wready}, 2'b00);
        resp = bresp;
        for (int k = 0; k < bdelay; k++) begin
            tick();
            check("b_hold", {bvalid, bresp}, {1'b1, resp});
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("b_done", {bvalid, awready, wready}, 3'b011);
    endtask

    task automatic do_read(input logic [31:0] a, input bit inj, input int hold,
                           output logic [31:0] d, output logic [1:0] resp);
        int hs;
        int n;
        d          = '0;
        resp       = 2'b11;
        araddr     = a;
        arvalid    = 1'b1;
        err_inj_rd = inj;
        n = 0;
        while (!arready && n < 40) begin
            tick();
            n++;
        end
        if (!arready) begin
            check("ar_timeout", 0, 1);
            arvalid = 1'b0;
            return;
        end
        hs = cyc;
        tick();
        arvalid    = 1'b0;
        err_inj_rd = 1'b0;
        check("ar_drop", arready, 0);
        n = 0;
        while (!rvalid && n < 40) begin
            tick();
            n++;
        end
        check("rd_latency", 64'(cyc - hs), 64'(RD_LAT));
        d    = rdata;
        resp = rresp;
        for (int k = 0; k < hold; k++) begin
            tick();
            check("r_hold", {rvalid, arready, rresp, rdata},
                  {1'b1, 1'b0, resp, d});
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("r_done", {rvalid, arready}, 2'b01);
    endtask

    typedef struct {
        bit          do_wr;
        logic [31:0] waddr;
        logic [31:0] wdat;
        logic [3:0]  strb;
        int          lead;
        logic [1:0]  exp_b;
        logic [31:0] raddr;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
    } vec_t;

    vec_t        tbl [10];
    logic [1:0]  r;
    logic [31:0] d;

    initial begin
        tbl[0] = '{1, 32'h0000, 32'h0123_4567, 4'hF,  0, 2'b00, 32'h0000, 32'h0123_4567, 2'b00};
        tbl[1] = '{1, 32'h0010, 32'hDEAD_BEEF, 4'hF,  2, 2'b00, 32'h0010, 32'hDEAD_BEEF, 2'b00};
        tbl[2] = '{1, 32'h0014, 32'hAAAA_AAAA, 4'hF, -1, 2'b00, 32'h0014, 32'hAAAA_AAAA, 2'b00};
        tbl[3] = '{1, 32'h0014, 32'h1122_3344, 4'h5,  0, 2'b00, 32'h0014, 32'hAA22_AA44, 2'b00};
        tbl[4] = '{1, 32'h0014, 32'hFFFF_FFFF, 4'h0,  1, 2'b00, 32'h0014, 32'hAA22_AA44, 2'b00};
        tbl[5] = '{1, 32'h0400, 32'hCAFE_F00D, 4'hF,  0, 2'b10, 32'h0400, 32'h0000_0000, 2'b10};
        tbl[6] = '{0, 32'h0000, 32'h0000_0000, 4'h0,  0, 2'b00, 32'h0000, 32'h0123_4567, 2'b00};
        tbl[7] = '{1, 32'h001B, 32'h5566_7788, 4'hF, -2, 2'b00, 32'h0018, 32'h5566_7788, 2'b00};
        tbl[8] = '{1, 32'hFFFF_FFFC, 32'h1, 4'hF,     0, 2'b10, 32'hFFFF_FFFC, 32'h0, 2'b10};
        tbl[9] = '{1, 32'h03FC, 32'h0BAD_F00D, 4'hF,  0, 2'b00, 32'h03FD, 32'h0BAD_F00D, 2'b00};

        // Reset hold and release
        repeat (5) tick();
        check("reset_outputs",
              {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata},
              '0);
        aresetn = 1'b1;
        tick();
        check("ready_after_release", {awready, wready, arready}, 3'b111);

        foreach (tbl[i]) begin
            if (tbl[i].do_wr) begin
                do_write(tbl[i].waddr, tbl[i].wdat, tbl[i].strb, tbl[i].lead,
                         1'b0, 1, r);
                check($sformatf("tbl%0d_bresp", i), r, tbl[i].exp_b);
                model_write(tbl[i].waddr, tbl[i].wdat, tbl[i].strb);
            end
            do_read(tbl[i].raddr, 1'b0, 0, d, r);
            check($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_d);
            check($sformatf("tbl%0d_rresp", i), r, tbl[i].exp_r);
        end

        // Backpressure on R with a long latency
        do_read(32'h10, 1'b0, 10, d, r);
        check("bp_rdata", d, 32'hDEAD_BEEF);

        // Same-edge read and write to 0x20
        do_write(32'h20, 32'h5A5A_5A5A, 4'hF, 0, 1'b0, 0, r);
        awaddr     = 32'h20;
        wdata      = 32'hC3C3_C3C3;
        wstrb      = 4'hF;
        araddr     = 32'h20;
        err_inj_rd = 1'b1;
        awvalid    = 1'b1;
        wvalid     = 1'b1;
        arvalid    = 1'b1;
        check("coll_readies", {awready, wready, arready}, 3'b111);
        tick();
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        arvalid    = 1'b0;
        err_inj_rd = 1'b0;
        for (int k = 0; k < 40 && !rvalid; k++) tick();
        check("coll_rdata", rdata, 32'h5A5A_5A5A);
        check("coll_rresp", rresp, INJ ? 2'b10 : 2'b00);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        for (int k = 0; k < 40 && !bvalid; k++) tick();
        check("coll_bresp", {bvalid, bresp}, 3'b100);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        do_read(32'h20, 1'b0, 0, d, r);
        check("coll_after", d, 32'hC3C3_C3C3);

        if (INJ) begin
            do_write(32'h24, 32'h7777_0001, 4'hF, 0, 1'b1, 0, r);
            check("inj_bresp", r, 2'b10);
            do_read(32'h24, 1'b0, 0, d, r);
            check("inj_wr_data", {r, d}, {2'b00, 32'h7777_0001});
        end

        // Reset with only AW captured: nothing commits
        do_write(32'h30, 32'h1111_1111, 4'hF, 0, 1'b0, 0, r);
        awaddr  = 32'h30;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        aresetn = 1'b0;
        tick();
        check("midrst_outputs", {awready, wready, bvalid, rvalid}, 4'b0000);
        aresetn = 1'b1;
        tick();
        do_write(32'h34, 32'h2222_2222, 4'hF, 0, 1'b0, 0, r);
        check("midrst_bresp", r, 2'b00);
        do_read(32'h30, 1'b0, 0, d, r);
        check("midrst_old", d, 32'h1111_1111);
        do_read(32'h34, 1'b0, 0, d, r);
        check("midrst_new", d, 32'h2222_2222);

        // Random traffic over 16 words plus out-of-range addresses
        for (int w = 32; w < 48; w++) begin
            d = $urandom;
            do_write(32'(w * 4), d, 4'hF, 0, 1'b0, 0, r);
            model_write(32'(w * 4), d, 4'hF);
        end
        for (int it = 0; it < 60; it++) begin
            logic [31:0] a;
            logic [31:0] wd;
            logic [3:0]  s;
            bit          inj;
            if ($urandom_range(0, 7) == 0)
                a = 32'h400 + 32'($urandom_range(0, 4000));
            else
                a = 32'h80 + 32'($urandom_range(0, 63));
            inj = INJ && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) begin
                wd = $urandom;
                s  = 4'($urandom_range(0, 15));
                do_write(a, wd, s, int'($urandom_range(0, 6)) - 3, inj,
                         int'($urandom_range(0, 2)), r);
                check("rnd_bresp", r,
                      (!ref_in_range(a) || inj) ? 2'b10 : 2'b00);
                model_write(a, wd, s);
            end else begin
                do_read(a, inj, int'($urandom_range(0, 3)), d, r);
                check("rnd_rresp", r,
                      (!ref_in_range(a) || inj) ? 2'b10 : 2'b00);
                check("rnd_rdata", d,
                      ref_in_range(a) ? model[ref_word(a)] : 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
